// File: rtl/div_unit.sv
// Sequential signed 32-bit divider (radix-2 restoring, one quotient bit per clock).
// Quotient truncates toward zero; the remainder takes the sign of the dividend.
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_start,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] div_low_out,
  output logic [31:0] div_hi_out,
  output logic        div_busy,
  output logic        div_done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [31:0] quo;
  logic [31:0] divisor;
  logic [31:0] rem;
  logic [4:0]  cnt;
  logic        q_neg;
  logic        r_neg;

  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] rs_abs;
  logic [31:0] rt_abs;

  // The remainder is always below the divisor (at most 2^31), so the shifted
  // value fits in 32 bits and bit 32 of the trial difference is a true sign.
  always_comb begin
    shifted = {rem, quo[31]};
    trial   = shifted - {1'b0, divisor};
    rs_abs  = rs_data[31] ? (32'd0 - rs_data) : rs_data;
    rt_abs  = rt_data[31] ? (32'd0 - rt_data) : rt_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      quo         <= 32'd0;
      divisor     <= 32'd0;
      rem         <= 32'd0;
      cnt         <= 5'd0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      div_low_out <= 32'd0;
      div_hi_out  <= 32'd0;
      div_busy    <= 1'b0;
      div_done    <= 1'b0;
      div_zero    <= 1'b0;
    end else begin
      div_done <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (div_start) begin
            if (rt_data == 32'd0) begin
              div_zero <= 1'b1;
            end else begin
              quo      <= rs_abs;
              divisor  <= rt_abs;
              rem      <= 32'd0;
              q_neg    <= rs_data[31] ^ rt_data[31];
              r_neg    <= rs_data[31];
              cnt      <= 5'd31;
              div_busy <= 1'b1;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          if (!trial[32]) begin
            rem <= trial[31:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= shifted[31:0];
            quo <= {quo[30:0], 1'b0};
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= FIX;
        end
        FIX: begin
          div_low_out <= q_neg ? (32'd0 - quo) : quo;
          div_hi_out  <= r_neg ? (32'd0 - rem) : rem;
          div_done    <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          div_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus divide-by-zero, busy-start,
// mid-run reset and back-to-back sequences.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        div_start = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic [31:0] div_low_out;
  logic [31:0] div_hi_out;
  logic        div_busy;
  logic        div_done;
  logic        div_zero;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int done_time = 0;

  div_unit dut (
    .clk         (clk),
    .reset       (reset),
    .div_start   (div_start),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .div_low_out (div_low_out),
    .div_hi_out  (div_hi_out),
    .div_busy    (div_busy),
    .div_done    (div_done),
    .div_zero    (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Launch one op; poke_at>0 raises a second start (9/4) during that cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int poke_at,
                        output int dcyc, output int bcyc);
    @(negedge clk);
    rs_data = a; rt_data = b; div_start = 1'b1;
    @(posedge clk);
    #1 div_start = 1'b0;
    dcyc = 0;
    bcyc = 0;
    for (int n = 1; n <= 50 && dcyc == 0; n++) begin
      @(negedge clk);
      if (n == poke_at) begin
        div_start = 1'b1; rs_data = 32'd9; rt_data = 32'd4;
      end else begin
        div_start = 1'b0;
      end
      if (div_busy) bcyc++;
      if (div_done) begin
        dcyc = n;
        done_time = cyc;
      end
    end
  endtask

  vec_t vecs[10];
  int dcyc, bcyc, t1, cnt;

  initial begin
    vecs[0] = '{32'd100,      32'd7,        32'h0000000E, 32'h00000002};
    vecs[1] = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2] = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001};
    vecs[3] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    vecs[4] = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0000000E, 32'hFFFFFFFE};
    vecs[5] = '{32'd0,        32'd5,        32'h00000000, 32'h00000000};
    vecs[6] = '{32'h80000000, 32'd1,        32'h80000000, 32'h00000000};
    vecs[7] = '{32'h12345678, 32'd1000,     32'h0004A90B, 32'h00000380};
    vecs[8] = '{32'd3,        32'd10,       32'h00000000, 32'h00000003};
    vecs[9] = '{32'd9,        32'd4,        32'h00000002, 32'h00000001};

    repeat (2) @(negedge clk);
    chk("rst_lo", div_low_out, 32'd0);
    chk("rst_hi", div_hi_out, 32'd0);
    chk("rst_busy", {31'd0, div_busy}, 32'd0);
    chk("rst_done", {31'd0, div_done}, 32'd0);
    chk("rst_zero", {31'd0, div_zero}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, 0, dcyc, bcyc);
      chk($sformatf("v%0d_latency", i), dcyc, 32'd34);
      chk($sformatf("v%0d_busy_cycles", i), bcyc, 32'd34);
      chk($sformatf("v%0d_lo", i), div_low_out, vecs[i].lo);
      chk($sformatf("v%0d_hi", i), div_hi_out, vecs[i].hi);
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", i), {31'd0, div_busy}, 32'd0);
      chk($sformatf("v%0d_idle_done", i), {31'd0, div_done}, 32'd0);
    end

    // Divide by zero after a 9/4 result is held.
    @(negedge clk);
    rs_data = 32'd5; rt_data = 32'd0; div_start = 1'b1;
    @(posedge clk);
    #1 div_start = 1'b0;
    @(negedge clk);
    chk("dz_zero_pulse", {31'd0, div_zero}, 32'd1);
    chk("dz_busy", {31'd0, div_busy}, 32'd0);
    chk("dz_done", {31'd0, div_done}, 32'd0);
    @(negedge clk);
    chk("dz_zero_end", {31'd0, div_zero}, 32'd0);
    chk("dz_done_after", {31'd0, div_done}, 32'd0);
    chk("dz_lo_kept", div_low_out, 32'd2);
    chk("dz_hi_kept", div_hi_out, 32'd1);

    // Start while busy must be ignored.
    run_op(32'd100, 32'd7, 10, dcyc, bcyc);
    chk("bs_latency", dcyc, 32'd34);
    chk("bs_lo", div_low_out, 32'd14);
    chk("bs_hi", div_hi_out, 32'd2);
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (div_busy || div_done) cnt++;
    end
    chk("bs_no_second_op", cnt, 32'd0);

    // Reset mid-CALC.
    @(negedge clk);
    rs_data = 32'd100; rt_data = 32'd7; div_start = 1'b1;
    @(posedge clk);
    #1 div_start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mr_lo", div_low_out, 32'd0);
    chk("mr_hi", div_hi_out, 32'd0);
    chk("mr_busy", {31'd0, div_busy}, 32'd0);
    chk("mr_done", {31'd0, div_done}, 32'd0);
    chk("mr_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (div_done || div_busy) cnt++;
    end
    chk("mr_no_done", cnt, 32'd0);
    run_op(32'hFFFFFFFF, 32'h00000010, 0, dcyc, bcyc);
    chk("mr2_latency", dcyc, 32'd34);
    chk("mr2_lo", div_low_out, 32'h00000000);
    chk("mr2_hi", div_hi_out, 32'hFFFFFFFF);

    // Back-to-back: second start is in the cycle after div_done.
    @(negedge clk);
    run_op(32'd1000, 32'd10, 0, dcyc, bcyc);
    t1 = done_time;
    chk("bb1_latency", dcyc, 32'd34);
    chk("bb1_lo", div_low_out, 32'd100);
    chk("bb1_hi", div_hi_out, 32'd0);
    run_op(32'h7FFFFFFF, 32'd1, 0, dcyc, bcyc);
    chk("bb2_latency", dcyc, 32'd34);
    chk("bb2_lo", div_low_out, 32'h7FFFFFFF);
    chk("bb2_hi", div_hi_out, 32'd0);
    chk("bb_spacing", done_time - t1, 32'd35);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
